// File: rtl/reset_sequencer.sv
// reset_sequencer: synchronizes the board reset, holds all domains in reset,
// then releases them one by one (lowest index first) with a fixed gap.
`timescale 1ns/1ps
module reset_sequencer #(
   parameter int NUM_DOMAINS = 4,
   parameter int STAGES      = 2,
   parameter int HOLD_CYCLES = 8,
   parameter int GAP_CYCLES  = 4
) (
   input  logic                   clk,
   input  logic                   async_rst_ni,
   input  logic                   sw_rst_req_i,
   output logic [NUM_DOMAINS-1:0] dom_rst_o,
   output logic                   busy_o,
   output logic                   done_o
);

   localparam int M1 = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int M2 = (M1 > NUM_DOMAINS) ? M1 : NUM_DOMAINS;
   localparam int CW = $clog2(M2) + 1;

   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
   localparam logic [CW-1:0] DOM_LAST  = CW'(NUM_DOMAINS - 1);

   typedef enum logic [1:0] {
      S_ASSERT,
      S_RELEASE,
      S_DONE
   } state_t;

   logic [STAGES-1:0]      r_sync;
   state_t                 r_state;
   logic [CW-1:0]          r_cnt;
   logic [CW-1:0]          r_idx;
   logic [NUM_DOMAINS-1:0] r_dom;
   logic                   r_busy;
   logic                   r_done;

   logic                   w_srst_n;
   state_t                 w_state_nxt;
   logic [CW-1:0]          w_cnt_nxt;
   logic [CW-1:0]          w_idx_nxt;
   logic [NUM_DOMAINS-1:0] w_dom_nxt;
   logic                   w_busy_nxt;
   logic                   w_done_nxt;

   // Assertion is immediate; only the deassertion travels through the chain.
   always_ff @(posedge clk or negedge async_rst_ni) begin
      if (!async_rst_ni) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], 1'b1};
      end
   end

   assign w_srst_n = r_sync[STAGES-1];

   always_ff @(posedge clk or negedge async_rst_ni) begin
      if (!async_rst_ni) begin
         r_state <= S_ASSERT;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_dom   <= '1;
         r_busy  <= 1'b1;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_idx   <= w_idx_nxt;
         r_dom   <= w_dom_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_idx_nxt   = r_idx;
      if (!w_srst_n || sw_rst_req_i) begin
         w_state_nxt = S_ASSERT;
         w_cnt_nxt   = '0;
         w_idx_nxt   = '0;
      end else begin
         unique case (r_state)
            S_ASSERT: begin
               if (r_cnt == HOLD_LAST) begin
                  w_cnt_nxt = '0;
                  w_idx_nxt = CW'(1);
                  w_state_nxt = (NUM_DOMAINS == 1) ? S_DONE : S_RELEASE;
               end else begin
                  w_cnt_nxt = r_cnt + CW'(1);
               end
            end
            S_RELEASE: begin
               if (r_cnt == GAP_LAST) begin
                  w_cnt_nxt = '0;
                  w_idx_nxt = r_idx + CW'(1);
                  if (r_idx == DOM_LAST) begin
                     w_state_nxt = S_DONE;
                  end
               end else begin
                  w_cnt_nxt = r_cnt + CW'(1);
               end
            end
            S_DONE: begin
               w_state_nxt = S_DONE;
            end
            default: begin
               w_state_nxt = S_ASSERT;
               w_cnt_nxt   = '0;
               w_idx_nxt   = '0;
            end
         endcase
      end
   end

   // Domains at or above the next index are still held in reset.
   always_comb begin
      w_dom_nxt = '0;
      for (int k = 0; k < NUM_DOMAINS; k++) begin
         w_dom_nxt[k] = (w_state_nxt == S_ASSERT) ||
                        ((w_state_nxt == S_RELEASE) && (CW'(k) >= w_idx_nxt));
      end
      w_busy_nxt = (w_state_nxt != S_DONE);
      w_done_nxt = (w_state_nxt == S_DONE);
   end

   assign dom_rst_o = r_dom;
   assign busy_o    = r_busy;
   assign done_o    = r_done;

endmodule
